// File: rtl/mini_calc_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mini_calc_driver : queues calculator commands, issues them one at a time,
//                    waits a fixed latency and returns results by valid/ready.
// Revision 1.0
// ----------------------------------------------------------------------------
module mini_calc_driver #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int INSTR_BIT_WIDTH = 4,
  parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP = 4'b1111,
  parameter int CALC_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         CmdValid,
  output logic                         CmdReady,
  input  logic [INSTR_BIT_WIDTH-1:0]   CmdInstruction,
  input  logic [INPUT_BIT_WIDTH-1:0]   CmdA,
  input  logic [INPUT_BIT_WIDTH-1:0]   CmdB,
  output logic [INSTR_BIT_WIDTH-1:0]   CalcInstruction,
  output logic [INPUT_BIT_WIDTH-1:0]   CalcInputA,
  output logic [INPUT_BIT_WIDTH-1:0]   CalcInputB,
  input  logic [INPUT_BIT_WIDTH-1:0]   CalcOutputA,
  input  logic [INPUT_BIT_WIDTH-1:0]   CalcOutputB,
  output logic                         ResValid,
  input  logic                         ResReady,
  output logic [INSTR_BIT_WIDTH-1:0]   ResInstruction,
  output logic [INPUT_BIT_WIDTH-1:0]   ResA,
  output logic [INPUT_BIT_WIDTH-1:0]   ResB,
  output logic [$clog2(FIFO_DEPTH):0]  QueueCount,
  output logic                         Busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WAIT_W  = $clog2(CALC_LATENCY + 1);
  localparam int ENTRY_W = INSTR_BIT_WIDTH + 2 * INPUT_BIT_WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  logic [ENTRY_W-1:0]         mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [1:0]                 state_q, state_d;
  logic [WAIT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic [INSTR_BIT_WIDTH-1:0] calc_instr_q, calc_instr_d;
  logic [INPUT_BIT_WIDTH-1:0] calc_a_q, calc_a_d;
  logic [INPUT_BIT_WIDTH-1:0] calc_b_q, calc_b_d;
  logic                       res_valid_q, res_valid_d;
  logic [INSTR_BIT_WIDTH-1:0] res_instr_q, res_instr_d;
  logic [INPUT_BIT_WIDTH-1:0] res_a_q, res_a_d;
  logic [INPUT_BIT_WIDTH-1:0] res_b_q, res_b_d;

  logic               cmd_ready;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  assign cmd_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push      = CmdValid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    calc_instr_d = calc_instr_q;
    calc_a_d     = calc_a_q;
    calc_b_d     = calc_b_q;
    res_valid_d  = res_valid_q;
    res_instr_d  = res_instr_q;
    res_a_d      = res_a_q;
    res_b_d      = res_b_q;
    pop          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        if (wait_cnt_q == WAIT_W'(1)) begin
          // calc_instr_q still carries the in-flight opcode at this edge
          res_valid_d  = 1'b1;
          res_a_d      = CalcOutputA;
          res_b_d      = CalcOutputB;
          res_instr_d  = calc_instr_q;
          calc_instr_d = CODE_INSTR_NOP;
          calc_a_d     = '0;
          calc_b_d     = '0;
          state_d      = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (ResReady) begin
          res_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      {calc_instr_d, calc_a_d, calc_b_d} = head;
      wait_cnt_d = WAIT_W'(CALC_LATENCY);
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = {CmdInstruction, CmdA, CmdB};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
    if (Reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      calc_instr_q <= CODE_INSTR_NOP;
      calc_a_q     <= '0;
      calc_b_q     <= '0;
      res_valid_q  <= 1'b0;
      res_instr_q  <= '0;
      res_a_q      <= '0;
      res_b_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      calc_instr_q <= calc_instr_d;
      calc_a_q     <= calc_a_d;
      calc_b_q     <= calc_b_d;
      res_valid_q  <= res_valid_d;
      res_instr_q  <= res_instr_d;
      res_a_q      <= res_a_d;
      res_b_q      <= res_b_d;
    end
  end

  assign CmdReady        = cmd_ready;
  assign CalcInstruction = calc_instr_q;
  assign CalcInputA      = calc_a_q;
  assign CalcInputB      = calc_b_q;
  assign ResValid        = res_valid_q;
  assign ResInstruction  = res_instr_q;
  assign ResA            = res_a_q;
  assign ResB            = res_b_q;
  assign QueueCount      = count_q;
  assign Busy            = (state_q != ST_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_mini_calc_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mini_calc_driver : directed bench with a behavioural mini calculator.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mini_calc_driver;

  localparam logic [3:0] NOP = 4'b1111;
  localparam logic [3:0] DIV = 4'b1110;
  localparam logic [3:0] MUL = 4'b1101;
  localparam logic [3:0] ADS = 4'b0111;
  localparam logic [3:0] MMX = 4'b1011;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       CmdValid = 1'b0;
  logic       CmdReady;
  logic [3:0] CmdInstruction = 4'h0;
  logic [7:0] CmdA = 8'h0;
  logic [7:0] CmdB = 8'h0;
  logic [3:0] CalcInstruction;
  logic [7:0] CalcInputA, CalcInputB;
  logic [7:0] CalcOutputA = 8'h0;
  logic [7:0] CalcOutputB = 8'h0;
  logic       ResValid;
  logic       ResReady = 1'b0;
  logic [3:0] ResInstruction;
  logic [7:0] ResA, ResB;
  logic [2:0] QueueCount;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  // command table: opcode, operands and hand-computed results
  logic [3:0] t_i [6];
  logic [7:0] t_a [6];
  logic [7:0] t_b [6];
  logic [7:0] t_ra [6];
  logic [7:0] t_rb [6];

  mini_calc_driver dut (
    .Clk(Clk), .Reset(Reset),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdInstruction(CmdInstruction), .CmdA(CmdA), .CmdB(CmdB),
    .CalcInstruction(CalcInstruction), .CalcInputA(CalcInputA), .CalcInputB(CalcInputB),
    .CalcOutputA(CalcOutputA), .CalcOutputB(CalcOutputB),
    .ResValid(ResValid), .ResReady(ResReady),
    .ResInstruction(ResInstruction), .ResA(ResA), .ResB(ResB),
    .QueueCount(QueueCount), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // calculator output stage, registered from the driver's registered inputs
  function automatic logic [15:0] calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    case (op)
      DIV:     calc = (b != 0) ? {a / b, a % b} : 16'h0;
      MUL:     calc = {p[7:0], p[15:8]};
      ADS:     calc = {a + b, a - b};
      MMX:     calc = (a < b) ? {a, b} : {b, a};
      default: calc = 16'h0;
    endcase
  endfunction

  always @(posedge Clk) begin
    {CalcOutputA, CalcOutputB} <= calc(CalcInstruction, CalcInputA, CalcInputB);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    CmdValid = 1'b1; CmdInstruction = op; CmdA = a; CmdB = b;
    n = 0;
    while (!CmdReady && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!CmdReady) begin
      errors++;
      $display("FAIL push_timeout: CmdReady=%0b required 1", CmdReady);
    end
    step();
    CmdValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    repeat (5) step();
    checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL reset_cmdready: got %0b want 1", CmdReady); end
    checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL reset_resvalid: got %0b want 0", ResValid); end
    checks++; if (CalcInstruction !== NOP) begin errors++; $display("FAIL reset_calc_instr: got %h want f", CalcInstruction); end
    checks++; if ({CalcInputA, CalcInputB} !== 16'h0) begin errors++; $display("FAIL reset_calc_ab: got %h want 0000", {CalcInputA, CalcInputB}); end
    checks++; if (QueueCount !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", QueueCount); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", Busy); end
    checks++; if ({ResInstruction, ResA, ResB} !== 20'h0) begin errors++; $display("FAIL reset_res: got %h want 0", {ResInstruction, ResA, ResB}); end
  endtask

  task automatic test_single();
    ResReady = 1'b0;
    push(DIV, 8'd17, 8'd5);
    checks++; if (QueueCount !== 3'd1) begin errors++; $display("FAIL single_queued: got %0d want 1", QueueCount); end
    checks++; if (CalcInstruction !== NOP) begin errors++; $display("FAIL single_no_fallthrough: got %h want f", CalcInstruction); end
    step();
    checks++; if ({CalcInstruction, CalcInputA, CalcInputB} !== {DIV, 8'd17, 8'd5}) begin
      errors++; $display("FAIL single_issue: got %h want %h", {CalcInstruction, CalcInputA, CalcInputB}, {DIV, 8'd17, 8'd5}); end
    checks++; if (QueueCount !== 3'd0) begin errors++; $display("FAIL single_popped: got %0d want 0", QueueCount); end
    step();
    checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL single_early: got %0b want 0", ResValid); end
    step();
    checks++; if (ResValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", ResValid); end
    checks++; if ({ResInstruction, ResA, ResB} !== {DIV, 8'd3, 8'd2}) begin
      errors++; $display("FAIL single_result: got %h want %h", {ResInstruction, ResA, ResB}, {DIV, 8'd3, 8'd2}); end
    checks++; if ({CalcInstruction, CalcInputA, CalcInputB} !== {NOP, 16'h0}) begin
      errors++; $display("FAIL single_calc_nop: got %h want f0000", {CalcInstruction, CalcInputA, CalcInputB}); end
    ResReady = 1'b1;
    step();
    checks++; if (ResValid !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL single_done: valid=%0b busy=%0b want 0 0", ResValid, Busy); end
  endtask

  task automatic test_ordered();
    logic [19:0] exp [3];
    int idx;
    exp[0] = {MUL, 8'h00, 8'h01};
    exp[1] = {ADS, 8'd13, 8'd7};
    exp[2] = {MMX, 8'd4, 8'd9};
    ResReady = 1'b1;
    push(MUL, 8'd16, 8'd16);
    push(ADS, 8'd10, 8'd3);
    push(MMX, 8'd9, 8'd4);
    idx = 0;
    for (int k = 0; k < 30; k++) begin
      if (ResValid) begin
        checks++;
        if (idx >= 3 || {ResInstruction, ResA, ResB} !== exp[idx]) begin
          errors++; $display("FAIL ordered_result%0d: got %h want %h", idx, {ResInstruction, ResA, ResB}, (idx < 3) ? exp[idx] : 20'h0);
        end
        idx++;
      end
      step();
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL ordered_count: got %0d results want 3", idx); end
  endtask

  task automatic test_backpressure();
    int idx;
    ResReady = 1'b0;
    for (int i = 0; i < 5; i++) push(t_i[i], t_a[i], t_b[i]);
    checks++; if (QueueCount !== 3'd4 || CmdReady !== 1'b0) begin
      errors++; $display("FAIL bp_full: count=%0d ready=%0b want 4 0", QueueCount, CmdReady); end
    checks++; if (ResValid !== 1'b1 || {ResInstruction, ResA, ResB} !== {t_i[0], t_ra[0], t_rb[0]}) begin
      errors++; $display("FAIL bp_first: valid=%0b res=%h want 1 %h", ResValid, {ResInstruction, ResA, ResB}, {t_i[0], t_ra[0], t_rb[0]}); end
    CmdValid = 1'b1; CmdInstruction = t_i[5]; CmdA = t_a[5]; CmdB = t_b[5];
    repeat (3) step();
    checks++; if (QueueCount !== 3'd4 || CmdReady !== 1'b0) begin
      errors++; $display("FAIL bp_stall: count=%0d ready=%0b want 4 0", QueueCount, CmdReady); end
    ResReady = 1'b1;
    step();
    ResReady = 1'b0;
    checks++; if (QueueCount !== 3'd3 || CmdReady !== 1'b1) begin
      errors++; $display("FAIL bp_release: count=%0d ready=%0b want 3 1", QueueCount, CmdReady); end
    step();
    CmdValid = 1'b0;
    checks++; if (QueueCount !== 3'd4) begin errors++; $display("FAIL bp_sixth: count=%0d want 4", QueueCount); end
    ResReady = 1'b1;
    idx = 1;
    for (int k = 0; k < 40; k++) begin
      if (ResValid) begin
        checks++;
        if (idx > 5 || {ResInstruction, ResA, ResB} !== {t_i[idx], t_ra[idx], t_rb[idx]}) begin
          errors++; $display("FAIL bp_drain%0d: got %h want %h", idx, {ResInstruction, ResA, ResB},
                             (idx <= 5) ? {t_i[idx], t_ra[idx], t_rb[idx]} : 20'h0);
        end
        idx++;
      end
      step();
    end
    checks++; if (idx != 6 || Busy !== 1'b0) begin errors++; $display("FAIL bp_drain_count: got %0d busy=%0b want 6 0", idx, Busy); end
  endtask

  task automatic test_back_to_back();
    int c;
    ResReady = 1'b0;
    for (int i = 0; i < 5; i++) push(t_i[i], t_a[i], t_b[i]);
    checks++; if (QueueCount !== 3'd4 || ResValid !== 1'b1) begin
      errors++; $display("FAIL b2b_setup: count=%0d valid=%0b want 4 1", QueueCount, ResValid); end
    ResReady = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      c = k / 3 + 1;
      checks++;
      if (k % 3 == 2) begin
        if (ResValid !== 1'b1 || {ResInstruction, ResA, ResB} !== {t_i[c], t_ra[c], t_rb[c]}) begin
          errors++; $display("FAIL b2b_result%0d: valid=%0b res=%h want 1 %h", k, ResValid, {ResInstruction, ResA, ResB}, {t_i[c], t_ra[c], t_rb[c]});
        end
      end else begin
        if (ResValid !== 1'b0 || {CalcInstruction, CalcInputA, CalcInputB} !== {t_i[c], t_a[c], t_b[c]}) begin
          errors++; $display("FAIL b2b_issue%0d: valid=%0b calc=%h want 0 %h", k, ResValid, {CalcInstruction, CalcInputA, CalcInputB}, {t_i[c], t_a[c], t_b[c]});
        end
      end
    end
    step();
    checks++; if (Busy !== 1'b0 || ResValid !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%0b valid=%0b want 0 0", Busy, ResValid); end
  endtask

  task automatic test_reset_wait();
    int seen;
    ResReady = 1'b1;
    push(t_i[0], t_a[0], t_b[0]);
    push(t_i[1], t_a[1], t_b[1]);
    push(t_i[2], t_a[2], t_b[2]);
    checks++; if (QueueCount !== 3'd2 || CalcInstruction !== t_i[0] || ResValid !== 1'b0) begin
      errors++; $display("FAIL rw_setup: count=%0d calc=%h valid=%0b want 2 %h 0", QueueCount, CalcInstruction, ResValid, t_i[0]); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (ResValid !== 1'b0 || QueueCount !== 3'd0 || Busy !== 1'b0) begin
      errors++; $display("FAIL rw_cleared: valid=%0b count=%0d busy=%0b want 0 0 0", ResValid, QueueCount, Busy); end
    checks++; if ({CalcInstruction, CalcInputA, CalcInputB} !== {NOP, 16'h0}) begin
      errors++; $display("FAIL rw_calc_nop: got %h want f0000", {CalcInstruction, CalcInputA, CalcInputB}); end
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (ResValid !== 1'b0 || CalcInstruction !== NOP) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rw_dropped: %0d active cycles want 0", seen); end
  endtask

  initial begin
    t_i[0] = ADS; t_a[0] = 8'd1;    t_b[0] = 8'd1;    t_ra[0] = 8'd2;  t_rb[0] = 8'd0;
    t_i[1] = ADS; t_a[1] = 8'd200;  t_b[1] = 8'd100;  t_ra[1] = 8'd44; t_rb[1] = 8'd100;
    t_i[2] = MMX; t_a[2] = 8'd7;    t_b[2] = 8'd3;    t_ra[2] = 8'd3;  t_rb[2] = 8'd7;
    t_i[3] = MUL; t_a[3] = 8'd3;    t_b[3] = 8'd5;    t_ra[3] = 8'd15; t_rb[3] = 8'd0;
    t_i[4] = DIV; t_a[4] = 8'd20;   t_b[4] = 8'd6;    t_ra[4] = 8'd3;  t_rb[4] = 8'd2;
    t_i[5] = NOP; t_a[5] = 8'h55;   t_b[5] = 8'hAA;   t_ra[5] = 8'd0;  t_rb[5] = 8'd0;

    test_reset();
    test_single();
    test_ordered();
    test_backpressure();
    test_back_to_back();
    test_reset_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
